// File: rtl/butterfly_pkg.sv
// Shared fixed-point constants and complex-word helpers for the butterfly blocks.
// A complex word is packed as {real, imag}; each half is signed two's complement.
package butterfly_pkg;

   localparam int HALF_SIZE = 37;
   localparam int WORD_SIZE = 74;
   localparam int FRACT_PT  = 18;

   typedef struct packed {
      logic signed [HALF_SIZE-1:0] re;
      logic signed [HALF_SIZE-1:0] im;
   } cword_t;

   function automatic logic signed [HALF_SIZE-1:0] cw_re(input logic [WORD_SIZE-1:0] w);
      cword_t c;
      c = w;
      return c.re;
   endfunction

   function automatic logic signed [HALF_SIZE-1:0] cw_im(input logic [WORD_SIZE-1:0] w);
      cword_t c;
      c = w;
      return c.im;
   endfunction

   function automatic logic [WORD_SIZE-1:0] cw_pack(input logic signed [HALF_SIZE-1:0] re,
                                                    input logic signed [HALF_SIZE-1:0] im);
      cword_t c;
      c.re = re;
      c.im = im;
      return c;
   endfunction

endpackage

// File: rtl/cmult_conj.sv
// Registered multiply of the butterfly difference by conj(W): the middle pipeline stage.
// Products are kept at full width; scaling happens downstream.
module cmult_conj
   import butterfly_pkg::*;
#(
   parameter int PROD_W = 2*HALF_SIZE + 2
)
(
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic signed [HALF_SIZE:0]   i_dr,
   input  logic signed [HALF_SIZE:0]   i_di,
   input  logic signed [HALF_SIZE-1:0] i_wr,
   input  logic signed [HALF_SIZE-1:0] i_wi,
   output logic signed [PROD_W-1:0]    o_pr,
   output logic signed [PROD_W-1:0]    o_pi
);

   logic signed [PROD_W-1:0] dr_x, di_x, wr_x, wi_x;

   assign dr_x = {{(PROD_W-HALF_SIZE-1){i_dr[HALF_SIZE]}}, i_dr};
   assign di_x = {{(PROD_W-HALF_SIZE-1){i_di[HALF_SIZE]}}, i_di};
   assign wr_x = {{(PROD_W-HALF_SIZE){i_wr[HALF_SIZE-1]}}, i_wr};
   assign wi_x = {{(PROD_W-HALF_SIZE){i_wi[HALF_SIZE-1]}}, i_wi};

   // S2: (dr + j*di) * (wr - j*wi)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_pr <= '0;
         o_pi <= '0;
      end else if (i_en) begin
         o_pr <= dr_x * wr_x + di_x * wi_x;
         o_pi <= di_x * wr_x - dr_x * wi_x;
      end
   end

endmodule

// File: rtl/butterfly_inverse_pipe.sv
// 3-stage inverse radix-2 butterfly: A = (A'+B')/2, B = conj(W)*(A'-B')/2, valid/ready stream.
// Define BFLY_INV_ROUND_EN to round half up before each shift instead of flooring.
module butterfly_inverse_pipe
   import butterfly_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [WORD_SIZE-1:0] i_A,
   input  logic [WORD_SIZE-1:0] i_B,
   input  logic [WORD_SIZE-1:0] i_twiddle,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [WORD_SIZE-1:0] o_A,
   output logic [WORD_SIZE-1:0] o_B
);

   localparam int PROD_W = 2*HALF_SIZE + 2;

   function automatic logic signed [HALF_SIZE-1:0] half_sum(input logic signed [HALF_SIZE:0] x);
      logic signed [HALF_SIZE:0] t;
`ifdef BFLY_INV_ROUND_EN
      t = x + (HALF_SIZE+1)'(1);
`else
      t = x;
`endif
      return HALF_SIZE'(t >>> 1);
   endfunction

   function automatic logic signed [HALF_SIZE-1:0] scale_prod(input logic signed [PROD_W-1:0] x);
      logic signed [PROD_W-1:0] t;
`ifdef BFLY_INV_ROUND_EN
      t = x + PROD_W'(1 << FRACT_PT);
`else
      t = x;
`endif
      return HALF_SIZE'(t >>> (FRACT_PT + 1));
   endfunction

   logic en;
   logic in_xfer;

   logic signed [HALF_SIZE-1:0] a_re, a_im, b_re, b_im;

   logic                        vld_p0, vld_p1;
   logic signed [HALF_SIZE:0]   sr_p0, si_p0, dr_p0, di_p0;
   logic signed [HALF_SIZE-1:0] wr_p0, wi_p0;
   logic signed [HALF_SIZE:0]   sr_p1, si_p1;
   logic signed [PROD_W-1:0]    pr_p1, pi_p1;

   assign en      = !o_valid || i_ready;
   assign o_ready = en;
   assign in_xfer = i_valid && en;

   assign a_re = cw_re(i_A);
   assign a_im = cw_im(i_A);
   assign b_re = cw_re(i_B);
   assign b_im = cw_im(i_B);

   // S1: sum / difference at one extra bit, capture twiddle
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_p0 <= 1'b0;
         sr_p0  <= '0;
         si_p0  <= '0;
         dr_p0  <= '0;
         di_p0  <= '0;
         wr_p0  <= '0;
         wi_p0  <= '0;
      end else if (en) begin
         vld_p0 <= in_xfer;
         sr_p0  <= {a_re[HALF_SIZE-1], a_re} + {b_re[HALF_SIZE-1], b_re};
         si_p0  <= {a_im[HALF_SIZE-1], a_im} + {b_im[HALF_SIZE-1], b_im};
         dr_p0  <= {a_re[HALF_SIZE-1], a_re} - {b_re[HALF_SIZE-1], b_re};
         di_p0  <= {a_im[HALF_SIZE-1], a_im} - {b_im[HALF_SIZE-1], b_im};
         wr_p0  <= cw_re(i_twiddle);
         wi_p0  <= cw_im(i_twiddle);
      end
   end

   // S2: conjugate multiply in the sub-module, sums ride alongside
   cmult_conj #(.PROD_W(PROD_W)) u_cmult (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (en),
      .i_dr  (dr_p0),
      .i_di  (di_p0),
      .i_wr  (wr_p0),
      .i_wi  (wi_p0),
      .o_pr  (pr_p1),
      .o_pi  (pi_p1)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_p1 <= 1'b0;
         sr_p1  <= '0;
         si_p1  <= '0;
      end else if (en) begin
         vld_p1 <= vld_p0;
         sr_p1  <= sr_p0;
         si_p1  <= si_p0;
      end
   end

   // S3: halve and truncate with wrap into the output registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_A     <= '0;
         o_B     <= '0;
      end else if (en) begin
         o_valid <= vld_p1;
         o_A     <= cw_pack(half_sum(sr_p1), half_sum(si_p1));
         o_B     <= cw_pack(scale_prod(pr_p1), scale_prod(pi_p1));
      end
   end

endmodule

// File: tb/tb_butterfly_inverse_pipe.sv
// Scoreboard bench for butterfly_inverse_pipe; expected words come from a wide-precision model.
// Honours BFLY_INV_ROUND_EN in the same way as the design.
module tb_butterfly_inverse_pipe;
   import butterfly_pkg::*;

   logic                 i_clk = 1'b0;
   logic                 i_rst, i_valid, i_ready;
   logic                 o_ready, o_valid;
   logic [WORD_SIZE-1:0] i_A, i_B, i_twiddle, o_A, o_B;

   typedef struct packed {
      logic [WORD_SIZE-1:0] a;
      logic [WORD_SIZE-1:0] b;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   n_in   = 0;
   int   n_out  = 0;

   butterfly_inverse_pipe dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_A       (i_A),
      .i_B       (i_B),
      .i_twiddle (i_twiddle),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_A       (o_A),
      .o_B       (o_B)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WORD_SIZE-1:0] pk(input logic signed [HALF_SIZE-1:0] re,
                                               input logic signed [HALF_SIZE-1:0] im);
      return {re, im};
   endfunction

   function automatic exp_t model(input logic [WORD_SIZE-1:0] a, b, w);
      logic signed [127:0] ar, ai, br, bi, wr, wi, rh, rp, t;
      exp_t e;
      ar = {{91{a[73]}}, a[73:37]};
      ai = {{91{a[36]}}, a[36:0]};
      br = {{91{b[73]}}, b[73:37]};
      bi = {{91{b[36]}}, b[36:0]};
      wr = {{91{w[73]}}, w[73:37]};
      wi = {{91{w[36]}}, w[36:0]};
`ifdef BFLY_INV_ROUND_EN
      rh = 128'sd1;
      rp = 128'sd1 <<< FRACT_PT;
`else
      rh = 128'sd0;
      rp = 128'sd0;
`endif
      t = (ar + br + rh) >>> 1;
      e.a[73:37] = t[36:0];
      t = (ai + bi + rh) >>> 1;
      e.a[36:0] = t[36:0];
      t = ((ar - br) * wr + (ai - bi) * wi + rp) >>> (FRACT_PT + 1);
      e.b[73:37] = t[36:0];
      t = ((ai - bi) * wr - (ar - br) * wi + rp) >>> (FRACT_PT + 1);
      e.b[36:0] = t[36:0];
      return e;
   endfunction

   // Monitor: inputs and outputs are stable at the falling edge
   always @(negedge i_clk) begin
      exp_t e;
      if (i_rst) begin
         sb.delete();
         n_in  = 0;
         n_out = 0;
      end else begin
         if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
               check_val("sb_underflow", 128'(sb.size()), 128'd1);
            end else begin
               e = sb.pop_front();
               check_val("sb_oA", 128'(o_A), 128'(e.a));
               check_val("sb_oB", 128'(o_B), 128'(e.b));
            end
            n_out++;
         end
         if (i_valid && o_ready) begin
            sb.push_back(model(i_A, i_B, i_twiddle));
            n_in++;
         end
      end
   end

   task automatic send(input logic [WORD_SIZE-1:0] a, b, w);
      i_A       = a;
      i_B       = b;
      i_twiddle = w;
      i_valid   = 1'b1;
      @(negedge i_clk);
      while (!o_ready) @(negedge i_clk);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge i_clk);
         lat++;
      end while (!o_valid && lat < 20);
      if (!o_valid) check_val("out_timeout", 128'(o_valid), 128'd1);
   endtask

   task automatic rand_beat(output logic [WORD_SIZE-1:0] a, b, w);
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      a = r[73:0];
      r = {$urandom(), $urandom(), $urandom()};
      b = r[73:0];
      r = {$urandom(), $urandom(), $urandom()};
      w = r[73:0];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int                   lat;
      logic [WORD_SIZE-1:0] ra, rb, rw, held_a, held_b;
      logic [HALF_SIZE-1:0] exp_re;

      i_rst     = 1'b1;
      i_valid   = 1'b0;
      i_ready   = 1'b1;
      i_A       = '0;
      i_B       = '0;
      i_twiddle = '0;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      check_val("rst_o_valid", 128'(o_valid), 128'd0);
      check_val("rst_o_A", 128'(o_A), 128'd0);
      check_val("rst_o_B", 128'(o_B), 128'd0);
      check_val("rst_o_ready", 128'(o_ready), 128'd1);

      // Basic recovery with W = 1
      @(posedge i_clk); #1;
      send(pk(37'sh100000, 37'sh180000), pk(-37'sd524288, -37'sd524288), pk(37'sd262144, 37'sd0));
      wait_valid(lat);
      check_val("t1_latency", 128'(lat), 128'd3);
      check_val("t1_oA", 128'(o_A), 128'(pk(37'sh40000, 37'sh80000)));
      check_val("t1_oB", 128'(o_B), 128'(pk(37'shC0000, 37'sh100000)));

      // Conjugate sign with W = j
      send(pk(37'sd262144, 37'sd262144), pk(37'sd262144, -37'sd262144), pk(37'sd0, 37'sd262144));
      wait_valid(lat);
      check_val("t2_oA", 128'(o_A), 128'(pk(37'sd262144, 37'sd0)));
      check_val("t2_oB", 128'(o_B), 128'(pk(37'sd262144, 37'sd0)));

      // Rounding boundary on the half sum
      send(pk(37'sd1, 37'sd0), '0, '0);
      wait_valid(lat);
`ifdef BFLY_INV_ROUND_EN
      exp_re = 37'd1;
`else
      exp_re = 37'd0;
`endif
      check_val("t5_pos_one", 128'(o_A[73:37]), 128'(exp_re));
      send(pk(-37'sd1, 37'sd0), '0, '0);
      wait_valid(lat);
`ifdef BFLY_INV_ROUND_EN
      exp_re = 37'd0;
`else
      exp_re = {HALF_SIZE{1'b1}};
`endif
      check_val("t5_neg_one", 128'(o_A[73:37]), 128'(exp_re));
      repeat (4) @(posedge i_clk); #1;

      // Back-to-back stream: one output per cycle
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               rand_beat(ra, rb, rw);
               send(ra, rb, rw);
            end
         end
         begin
            int l3;
            wait_valid(l3);
            for (int k = 0; k < 8; k++) begin
               check_val("t3_throughput", 128'(o_valid), 128'd1);
               @(negedge i_clk);
            end
         end
      join
      repeat (6) @(posedge i_clk); #1;

      // Output stall for 5 cycles
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               rand_beat(ra, rb, rw);
               send(ra, rb, rw);
            end
         end
         begin
            int l4;
            wait_valid(l4);
            @(posedge i_clk); #1;
            i_ready = 1'b0;
            held_a  = o_A;
            held_b  = o_B;
            repeat (5) begin
               @(negedge i_clk);
               check_val("t4_o_ready", 128'(o_ready), 128'd0);
               check_val("t4_o_valid", 128'(o_valid), 128'd1);
               check_val("t4_hold_A", 128'(o_A), 128'(held_a));
               check_val("t4_hold_B", 128'(o_B), 128'(held_b));
            end
            @(posedge i_clk); #1;
            i_ready = 1'b1;
         end
      join
      repeat (8) @(posedge i_clk); #1;
      check_val("t4_drain", 128'(sb.size()), 128'd0);
      check_val("t4_count", 128'(n_out), 128'(n_in));

      // Reset with three beats in flight
      for (int i = 0; i < 3; i++) begin
         rand_beat(ra, rb, rw);
         send(ra, rb, rw);
      end
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      @(negedge i_clk);
      check_val("t6_o_valid", 128'(o_valid), 128'd0);
      check_val("t6_o_A", 128'(o_A), 128'd0);
      check_val("t6_o_B", 128'(o_B), 128'd0);
      check_val("t6_o_ready", 128'(o_ready), 128'd1);
      @(posedge i_clk); #1;
      rand_beat(ra, rb, rw);
      send(ra, rb, rw);
      wait_valid(lat);
      check_val("t6_latency", 128'(lat), 128'd3);

      repeat (6) @(negedge i_clk);
      check_val("final_drain", 128'(sb.size()), 128'd0);
      check_val("final_count", 128'(n_out), 128'(n_in));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
